// File: rtl/eth_rx_pkg.sv
// Shared types, constants and helpers for the Ethernet receive header parser.
// Holds the parser state enum, header word indices and byte-count helpers.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        S_W0    = 3'd0,
        S_W1    = 3'd1,
        S_W2    = 3'd2,
        S_W3    = 3'd3,
        S_PL    = 3'd4,
        S_FLUSH = 3'd5
    } state_e;

    localparam int HDR_BYTES = 14;

    localparam logic [1:0] W_DMAC_HI = 2'd0;
    localparam logic [1:0] W_MAC_MID = 2'd1;
    localparam logic [1:0] W_SMAC_LO = 2'd2;
    localparam logic [1:0] W_ETYPE   = 2'd3;

    // Byte count of a contiguous MSB-first keep mask.
    function automatic logic [2:0] keep_pop(input logic [3:0] k);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, k[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [2:0]  b);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/eth_pl_realign.sv
// Payload realigner: shifts the payload by the 16-bit header offset.
// Ports: ld_i/pl_i/flush_i controls from the parser FSM, data/keep/last in,
// registered AXI-Stream-like payload word out.
module eth_pl_realign
    import eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_i,
    input  logic        pl_i,
    input  logic        flush_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  keep_i,
    input  logic        last_i,
    output logic [31:0] pl_data_o,
    output logic [3:0]  pl_keep_o,
    output logic        pl_valid_o,
    output logic        pl_last_o
);

    logic [15:0] res_q, res_d;
    logic [1:0]  res_cnt_q, res_cnt_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  keep_q, keep_d;
    logic        vld_q, vld_d;
    logic        lst_q, lst_d;
    logic [3:0]  k;

    always_comb begin
        k         = last_i ? keep_i : 4'hF;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        data_d    = data_q;
        keep_d    = keep_q;
        vld_d     = 1'b0;
        lst_d     = 1'b0;
        if (flush_i) begin
            data_d    = {res_q, 16'h0000};
            keep_d    = {res_cnt_q != 2'd0, res_cnt_q == 2'd2, 2'b00};
            vld_d     = 1'b1;
            lst_d     = 1'b1;
            res_cnt_d = 2'd0;
        end else if (ld_i || pl_i) begin
            res_d     = data_i[15:0];
            // popcount of the low half of a contiguous keep
            res_cnt_d = {k[1] & k[0], k[1] ^ k[0]};
            if (pl_i) begin
                data_d = {res_q, data_i[31:16]};
                keep_d = {2'b11, k[3], k[2]};
                vld_d  = 1'b1;
                // a residue left behind means a flush word follows
                lst_d  = ~k[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= 16'h0000;
            res_cnt_q <= 2'd0;
            data_q    <= 32'h0;
            keep_q    <= 4'h0;
            vld_q     <= 1'b0;
            lst_q     <= 1'b0;
        end else begin
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            vld_q     <= vld_d;
            lst_q     <= lst_d;
        end
    end

    assign pl_data_o  = data_q;
    assign pl_keep_o  = keep_q;
    assign pl_valid_o = vld_q;
    assign pl_last_o  = lst_q;

endmodule

// File: rtl/eth_rx_hdr_parser.sv
// Ethernet receive header parser: extracts MACs/EtherType, counts bytes.
// Ports: 32-bit MSB-first frame stream in, header fields, realigned payload
// stream and end-of-frame status (byte count, runt, oversize) out.
module eth_rx_hdr_parser
    import eth_rx_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_rx_data,
    input  logic [3:0]  i_rx_tkeep,
    input  logic        i_rxd_tvalid,
    input  logic        i_rx_tlast,
    output logic        o_rx_tready,
    output logic [47:0] o_dest_mac,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_ether_type,
    output logic        o_hdr_valid,
    output logic [31:0] o_pl_data,
    output logic [3:0]  o_pl_tkeep,
    output logic        o_pl_tvalid,
    output logic        o_pl_tlast,
    output logic        o_frame_done,
    output logic [15:0] o_byte_count,
    output logic        o_err_runt,
    output logic        o_err_oversize
);

    localparam logic [15:0] MIN_B = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_B = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0] HDR_B = 16'(HDR_BYTES);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] sh_dmac_q, sh_dmac_d;
    logic [47:0] sh_smac_q, sh_smac_d;
    logic [47:0] dmac_q, dmac_d;
    logic [47:0] smac_q, smac_d;
    logic [15:0] etype_q, etype_d;
    logic        hdr_vld_q, hdr_vld_d;
    logic        done_q, done_d;
    logic [15:0] bc_q, bc_d;
    logic        runt_q, runt_d;
    logic        over_q, over_d;

    logic        acc;
    logic [2:0]  inc;
    logic [15:0] cnt_fin;
    logic [15:0] fin_val;
    logic        fin;
    logic        early;

    assign o_rx_tready = (state_q != S_FLUSH);
    assign acc         = i_rxd_tvalid & o_rx_tready;
    assign inc         = i_rx_tlast ? keep_pop(i_rx_tkeep) : 3'd4;
    assign cnt_fin     = sat_add((state_q == S_W0) ? 16'h0 : cnt_q, inc);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_dmac_d = sh_dmac_q;
        sh_smac_d = sh_smac_q;
        dmac_d    = dmac_q;
        smac_d    = smac_q;
        etype_d   = etype_q;
        hdr_vld_d = 1'b0;
        done_d    = 1'b0;
        bc_d      = bc_q;
        runt_d    = runt_q;
        over_d    = over_q;
        fin       = 1'b0;
        fin_val   = cnt_fin;
        early     = 1'b0;
        if (state_q == S_FLUSH) begin
            state_d = S_W0;
            fin     = 1'b1;
            fin_val = cnt_q;
        end else if (acc) begin
            cnt_d = cnt_fin;
            // header words land in shadows so outputs hold until the pulse
            if (!state_q[2]) begin
                case (state_q[1:0])
                    W_DMAC_HI: sh_dmac_d[47:16] = i_rx_data;
                    W_MAC_MID: begin
                        sh_dmac_d[15:0]  = i_rx_data[31:16];
                        sh_smac_d[47:32] = i_rx_data[15:0];
                    end
                    W_SMAC_LO: sh_smac_d[31:0] = i_rx_data;
                    W_ETYPE: begin
                        dmac_d    = sh_dmac_q;
                        smac_d    = sh_smac_q;
                        etype_d   = i_rx_data[31:16];
                        hdr_vld_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            case (state_q)
                S_W0:    state_d = S_W1;
                S_W1:    state_d = S_W2;
                S_W2:    state_d = S_W3;
                S_W3:    state_d = S_PL;
                S_PL:    state_d = S_PL;
                default: state_d = S_W0;
            endcase
            if (i_rx_tlast) begin
                early = !state_q[2] && (state_q != S_W3);
                if ((state_q == S_W3 || state_q == S_PL) && i_rx_tkeep[1]) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_W0;
                    fin     = 1'b1;
                end
            end
        end
        if (fin) begin
            done_d = 1'b1;
            bc_d   = fin_val;
            runt_d = (fin_val < MIN_B) || (fin_val < HDR_B) || early;
            over_d = (fin_val > MAX_B);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_W0;
            cnt_q     <= 16'h0;
            sh_dmac_q <= 48'h0;
            sh_smac_q <= 48'h0;
            dmac_q    <= 48'h0;
            smac_q    <= 48'h0;
            etype_q   <= 16'h0;
            hdr_vld_q <= 1'b0;
            done_q    <= 1'b0;
            bc_q      <= 16'h0;
            runt_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_dmac_q <= sh_dmac_d;
            sh_smac_q <= sh_smac_d;
            dmac_q    <= dmac_d;
            smac_q    <= smac_d;
            etype_q   <= etype_d;
            hdr_vld_q <= hdr_vld_d;
            done_q    <= done_d;
            bc_q      <= bc_d;
            runt_q    <= runt_d;
            over_q    <= over_d;
        end
    end

    eth_pl_realign u_realign (
        .clk       (clk),
        .rst       (rst),
        .ld_i      (acc && state_q == S_W3),
        .pl_i      (acc && state_q == S_PL),
        .flush_i   (state_q == S_FLUSH),
        .data_i    (i_rx_data),
        .keep_i    (i_rx_tkeep),
        .last_i    (i_rx_tlast),
        .pl_data_o (o_pl_data),
        .pl_keep_o (o_pl_tkeep),
        .pl_valid_o(o_pl_tvalid),
        .pl_last_o (o_pl_tlast)
    );

    assign o_dest_mac     = dmac_q;
    assign o_src_mac      = smac_q;
    assign o_ether_type   = etype_q;
    assign o_hdr_valid    = hdr_vld_q;
    assign o_frame_done   = done_q;
    assign o_byte_count   = bc_q;
    assign o_err_runt     = runt_q;
    assign o_err_oversize = over_q;

endmodule

// File: doc/eth_rx_hdr_parser.md
Name: eth_rx_hdr_parser

Overview:
Receive-side consumer of the 32-bit MSB-first Ethernet frame stream that the frame generator drives onto i_rx_data/i_rxd_tvalid/i_rx_tlast. It extracts destination MAC, source MAC and EtherType, and counts frame bytes. It realigns the payload, which starts at byte 14, to word boundaries and forwards it as an AXI-Stream-like output. The ACL match logic sits downstream and consumes the header fields and the payload stream.

Parameters:
MAX_FRAME_BYTES  1518  frames with byte count above this flag o_err_oversize
MIN_FRAME_BYTES  60    frames with byte count below this flag o_err_runt

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_rx_data  in  32  frame word; byte n of the word is at [31-8n -: 8]
i_rx_tkeep  in  4  byte enables, MSB-first contiguous (F,E,C,8); meaningful only on the tlast word
i_rxd_tvalid  in  1  input word valid
i_rx_tlast  in  1  last word of frame
o_rx_tready  out  1  parser can accept a word
o_dest_mac  out  48  destination MAC
o_src_mac  out  48  source MAC
o_ether_type  out  16  EtherType
o_hdr_valid  out  1  one-cycle pulse; header fields valid and held until next pulse
o_pl_data  out  32  realigned payload word, MSB-first
o_pl_tkeep  out  4  payload byte enables
o_pl_tvalid  out  1  payload word valid
o_pl_tlast  out  1  last payload word
o_frame_done  out  1  one-cycle pulse at end of frame
o_byte_count  out  16  total frame bytes; valid with o_frame_done
o_err_runt  out  1  valid with o_frame_done
o_err_oversize  out  1  valid with o_frame_done

Behaviour:
- Reset values: all outputs 0 except o_rx_tready=1. State goes to S_W0.
- Accept = i_rxd_tvalid & o_rx_tready. Nothing advances without an accept, so tvalid gaps of any length are legal.
- o_rx_tready=0 only in S_FLUSH. There is no downstream backpressure.
- Word map:
  - W0 = dmac[47:16]
  - W1 = {dmac[15:0], smac[47:32]}
  - W2 = smac[31:0]
  - W3 = {ethertype, payload bytes 0-1}
  - W4 onwards = payload
- States: S_W0 -> S_W1 -> S_W2 -> S_W3 -> S_PL, advancing on each accept. From S_PL, go to S_FLUSH or S_W0 on a tlast accept. S_FLUSH -> S_W0 after one cycle.
- Header fields are registered as their words are accepted. o_hdr_valid pulses the cycle after the W3 accept.
- Residue register res[15:0] and res_cnt (0..2):
  - W3 accept: res=W3[15:0]. res_cnt = 2 if not tlast; otherwise the popcount of tkeep[1:0].
- S_PL accept, one cycle latency:
  - o_pl_data={res, W[31:16]}
  - o_pl_tkeep={2'b11, k[3], k[2]}
  - then res=W[15:0]
  - On a non-last word, k is treated as 4'hF.
- Tlast handling in S_PL:
  - If k[1]=1, residue remains: emit without tlast, then go to S_FLUSH. S_FLUSH emits {res,16'h0}, tkeep {1,k[0],0,0}... more precisely tkeep {1, k[0], 0, 0} with o_pl_tlast=1.
  - Otherwise emit the word with o_pl_tlast=1 and return to S_W0.
- Tlast on W3: if res_cnt>0, emit a single {res,16'h0} word with tlast via S_FLUSH. If res_cnt=0, no payload is emitted.
- Byte count: 4 per accepted non-last word, popcount(tkeep) on the tlast word. The counter saturates at 16'hFFFF.
- o_frame_done pulses the cycle after the tlast accept. In the flush case it pulses on the same cycle as the flush word.
  - o_err_runt = (count < MIN_FRAME_BYTES)
  - o_err_oversize = (count > MAX_FRAME_BYTES)
- Tlast in S_W0, S_W1 or S_W2: no o_hdr_valid pulse and no payload. o_frame_done pulses with o_err_runt=1.
- rst mid-frame: outputs are cleared on the next edge and no o_pl_tlast or o_frame_done is emitted for the truncated frame. The next accepted word is parsed as W0.

Decomposition:
- Package eth_rx_pkg holds:
  - the state enum typedef
  - localparam HDR_BYTES=14
  - word-index constants W_DMAC_HI..W_ETYPE
  - the popcount function for contiguous tkeep
- One sub-module is natural: eth_pl_realign, which holds the 16-bit residue shifter, the flush logic and the payload output registers. The parser FSM stays in the top module.

Test Plan:
- Default frame: dest 001422012345, src 0014226789AB, type 0800, 1514 bytes, payload i%256, last tkeep=C.
  - Required: o_dest_mac/o_src_mac/o_ether_type match, o_hdr_valid pulses once.
  - First payload word 00010203, 375 payload words.
  - Last word D8D9DADB with tkeep F and tlast. o_byte_count=1514, no errors.
- Same frame with tvalid held low for 3 cycles after W1 and for 1 cycle mid-payload -> identical outputs. o_hdr_valid arrives the cycle after the W3 accept.
- 16-byte frame, W3 tlast with tkeep F -> one payload word {W3[15:0],0000} with tkeep C and tlast. o_rx_tready=0 for that cycle. count=16, o_err_runt=1.
- 12-byte frame, tlast on W2 -> no o_hdr_valid, no payload. count=12, o_err_runt=1.
- 1522-byte frame, last tkeep=C -> o_err_oversize=1, count=1522.
- 1515-byte frame (last tkeep=E) -> the data word is emitted, then a flush word with tkeep 8 and tlast.
- rst asserted mid-payload -> o_pl_tvalid=0 the next cycle, no o_frame_done. The following default frame is parsed correctly.
